mem_arbiter: RTL and testbench

- Shares one single-ported memory between the core's instruction-fetch port and its data (load/store) port.
- Requests use valid/ready handshakes; at most one memory read is outstanding at a time.
- Data port has priority. A starvation counter guarantees fetch progress.
- Sits between the pipeline core's pc/instr and address/write_data/write_mask/read_data ports and a unified memory with variable read latency.

---
 rtl/core_pkg.sv | 19 +
 rtl/arb_starve_counter.sv | 23 ++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and default widths for the core's memory-side blocks.
package core_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter issue state: free to issue, or one read in flight.
  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } arb_state_t;

  // Which port the outstanding read belongs to.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants taken while fetch waits.
module arb_starve_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  // Clear beats increment; increment stops at MAX; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst)                cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// load/store. Data has priority; a starvation counter forces a fetch
// grant after STARVE_MAX back-to-back data grants. One read in flight.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              issue_ok, gnt_fetch, gnt_data, rd_accept, resp;
  logic              starve_max;
  logic [CNT_W-1:0]  starve_cnt;

  arb_starve_counter #(.MAX(STARVE_MAX), .W(CNT_W)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr    (~i_req | i_ready),
    .inc    (d_ready & i_req),
    .cnt    (starve_cnt),
    .at_max (starve_max)
  );

  // Issue window, grant choice and the mux onto the memory port.
  // Everything is gated by rst so outputs read 0 throughout reset.
  always_comb begin
    issue_ok  = rst & ((state_q == IDLE) | mem_rvalid);
    gnt_fetch = i_req & (~d_req | starve_max);
    gnt_data  = d_req & ~gnt_fetch;
    mem_en    = issue_ok & (i_req | d_req);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (mem_en && gnt_data) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wmask = d_wmask;
    end else if (mem_en && gnt_fetch) begin
      mem_addr  = i_addr;
    end
    i_ready   = mem_en & gnt_fetch & mem_ready;
    d_ready   = mem_en & gnt_data & mem_ready;
    rd_accept = i_ready | (d_ready & ~d_we);
  end

  // Read data is routed to the owner in the same cycle it returns;
  // the other port keeps showing its previous word.
  always_comb begin
    resp     = rst & (state_q == WAIT_RD) & mem_rvalid;
    i_rvalid = resp & (owner_q == OWN_FETCH);
    d_rvalid = resp & (owner_q == OWN_DATA);
    i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
  end

  // Next state: a returning read frees the slot unless a new read
  // is accepted in that same cycle (back-to-back reads).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_accept)  state_d = WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_d = rd_accept ? WAIT_RD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, read owner and held response data. A reset mid-read
  // drops the read; its late rvalid then lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_accept) owner_q   <= d_ready ? OWN_DATA : OWN_FETCH;
      if (i_rvalid)  i_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch read, store priority,
// starvation release, back-pressure and reset in the middle of a read.
module tb_mem_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ready(d_ready), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after posedge; outputs sampled at negedge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_en"},   mem_en,   1'b0);
    chk({tag, ".i_ready"},  i_ready,  1'b0);
    chk({tag, ".d_ready"},  d_ready,  1'b0);
    chk({tag, ".i_rvalid"}, i_rvalid, 1'b0);
    chk({tag, ".d_rvalid"}, d_rvalid, 1'b0);
  endtask

  logic [5:0] exp_d, exp_i;

  initial begin
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; mem_ready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;

    // 1. reset with stray rvalid, then idle
    for (int k = 0; k < 3; k++) begin
      settle();
      chk_quiet("rst");
      chk("rst.i_rdata", i_rdata, 32'h0);
      chk("rst.d_rdata", d_rdata, 32'h0);
      chk("rst.mem_addr", mem_addr, 32'h0);
      chk("rst.mem_we", mem_we, 1'b0);
      adv();
    end
    rst = 1'b1;
    settle();
    chk_quiet("idle");
    chk("idle.state", dut.state_q, IDLE);
    adv();
    mem_rvalid = 1'b0;

    // 2. single fetch read, data back two cycles after accept
    i_req = 1'b1; i_addr = 32'h100;
    settle();
    chk("f.i_ready", i_ready, 1'b1);
    chk("f.mem_en", mem_en, 1'b1);
    chk("f.mem_addr", mem_addr, 32'h100);
    chk("f.mem_we", mem_we, 1'b0);
    adv();
    i_req = 1'b0;
    settle();
    chk("f.wait_en", mem_en, 1'b0);
    chk("f.wait_rv", i_rvalid, 1'b0);
    adv();
    mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    settle();
    chk("f.i_rvalid", i_rvalid, 1'b1);
    chk("f.i_rdata", i_rdata, 32'h0050_0093);
    chk("f.d_rvalid", d_rvalid, 1'b0);
    adv();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    settle();
    chk("f.hold_rv", i_rvalid, 1'b0);
    chk("f.hold_rdata", i_rdata, 32'h0050_0093);
    chk("f.state", dut.state_q, IDLE);
    adv();

    // 3. store beats a simultaneous fetch, then fetch goes next
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    d_wmask = 4'b0001; i_req = 1'b1; i_addr = 32'h104;
    settle();
    chk("st.d_ready", d_ready, 1'b1);
    chk("st.i_ready", i_ready, 1'b0);
    chk("st.mem_we", mem_we, 1'b1);
    chk("st.mem_wmask", mem_wmask, 4'b0001);
    chk("st.mem_addr", mem_addr, 32'h2000);
    chk("st.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    adv();
    d_req = 1'b0; d_we = 1'b0;
    settle();
    chk("st.state", dut.state_q, IDLE);
    chk("st.cnt", dut.starve_cnt, 3'd1);
    chk("st.i_ready", i_ready, 1'b1);
    chk("st.f_addr", mem_addr, 32'h104);
    chk("st.f_wmask", mem_wmask, 4'b0000);
    adv();
    i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    settle();
    chk("st.i_rvalid", i_rvalid, 1'b1);
    chk("st.i_rdata", i_rdata, 32'h1111_1111);
    adv();
    mem_rvalid = 1'b0;

    // 4. starvation: 4 loads, forced fetch, then data again
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h3000; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    exp_d = 6'b101111; exp_i = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("sv.d_ready%0d", k), d_ready, exp_d[k]);
      chk($sformatf("sv.i_ready%0d", k), i_ready, exp_i[k]);
      chk($sformatf("sv.cnt%0d", k), dut.starve_cnt, (k < 5) ? k : 0);
      chk($sformatf("sv.addr%0d", k), mem_addr, exp_i[k] ? 32'h200 : 32'h3000);
      chk($sformatf("sv.d_rv%0d", k), d_rvalid, (k >= 1 && k != 5));
      chk($sformatf("sv.i_rv%0d", k), i_rvalid, (k == 5));
      adv();
    end
    i_req = 1'b0; d_req = 1'b0;
    settle();
    chk("sv.last_rv", d_rvalid, 1'b1);
    chk("sv.last_rdata", d_rdata, 32'hA5A5_A5A5);
    chk("sv.last_en", mem_en, 1'b0);
    adv();
    mem_rvalid = 1'b0;

    // 5. back-pressure with both ports requesting; counter holds
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4004; i_req = 1'b1; i_addr = 32'h700;
    settle();
    chk("bp.pre_dready", d_ready, 1'b1);
    adv();
    d_we = 1'b0; d_addr = 32'h4000; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("bp.d_ready%0d", k), d_ready, 1'b0);
      chk($sformatf("bp.i_ready%0d", k), i_ready, 1'b0);
      chk($sformatf("bp.en%0d", k), mem_en, 1'b1);
      chk($sformatf("bp.addr%0d", k), mem_addr, 32'h4000);
      chk($sformatf("bp.cnt%0d", k), dut.starve_cnt, 3'd1);
      adv();
    end
    mem_ready = 1'b1;
    settle();
    chk("bp.d_ready", d_ready, 1'b1);
    adv();
    d_req = 1'b0; i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    settle();
    chk("bp.d_rvalid", d_rvalid, 1'b1);
    chk("bp.d_rdata", d_rdata, 32'h55);
    chk("bp.i_rvalid", i_rvalid, 1'b0);
    chk("bp.i_rdata", i_rdata, 32'hA5A5_A5A5);
    adv();
    mem_rvalid = 1'b0;

    // 6. reset while a fetch read is outstanding
    i_req = 1'b1; i_addr = 32'h500;
    settle();
    chk("rr.i_ready", i_ready, 1'b1);
    adv();
    i_req = 1'b0; rst = 1'b0;
    settle();
    chk_quiet("rr.rst");
    adv();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    settle();
    chk("rr.late_rv", i_rvalid, 1'b0);
    chk("rr.state", dut.state_q, IDLE);
    chk("rr.i_rdata", i_rdata, 32'h0);
    adv();
    mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h600;
    settle();
    chk("rr.next_ready", i_ready, 1'b1);
    chk("rr.next_addr", mem_addr, 32'h600);
    adv();
    i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66;
    settle();
    chk("rr.next_rv", i_rvalid, 1'b1);
    chk("rr.next_rdata", i_rdata, 32'h66);
    adv();
    mem_rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
